// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads to instruction memory
// and presents {pc, instr, valid} on the IF/ID register, honouring stall and redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_instr,
  output logic        IF_valid
);

  // state   | meaning
  // S_FETCH | read of r_pc outstanding
  // S_DROP  | squashed read still in flight; address frozen, r_pending_pc is next pc
  // S_HOLD  | fetched word parked in r_hold_instr while stalled, no read
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DROP  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_pending_pc, w_pending_nxt;
  logic [31:0] r_hold_instr, w_hold_nxt;
  logic [31:0] r_if_pc, w_if_pc_nxt;
  logic [31:0] r_if_instr, w_if_instr_nxt;
  logic        r_if_valid, w_if_valid_nxt;

  logic [31:0] w_target;
  logic [31:0] w_pc_inc;
  logic        w_unused;

  assign w_target = {redirect_pc[31:2], 2'b00};
  assign w_pc_inc = r_pc + 32'd4;
  assign w_unused = &{1'b0, redirect_pc[1:0]};

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pending_nxt  = r_pending_pc;
    w_hold_nxt     = r_hold_instr;
    w_if_pc_nxt    = r_if_pc;
    w_if_instr_nxt = r_if_instr;
    w_if_valid_nxt = r_if_valid;
    case (r_state)
      S_FETCH: begin
        if (redirect) begin
          w_if_valid_nxt = 1'b0;
          if (imem_resp) begin
            w_pc_nxt = w_target;
          end else begin
            w_pending_nxt = w_target;
            w_state_nxt   = S_DROP;
          end
        end else if (imem_resp) begin
          if (!stall) begin
            w_if_pc_nxt    = r_pc;
            w_if_instr_nxt = imem_rdata;
            w_if_valid_nxt = 1'b1;
            w_pc_nxt       = w_pc_inc;
          end else begin
            w_hold_nxt  = imem_rdata;
            w_state_nxt = S_HOLD;
          end
        end else if (!stall) begin
          w_if_valid_nxt = 1'b0;
        end
      end
      S_DROP: begin
        w_if_valid_nxt = 1'b0;
        if (imem_resp) begin
          w_pc_nxt    = redirect ? w_target : r_pending_pc;
          w_state_nxt = S_FETCH;
        end else if (redirect) begin
          w_pending_nxt = w_target;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_if_valid_nxt = 1'b0;
          w_pc_nxt       = w_target;
          w_state_nxt    = S_FETCH;
        end else if (!stall) begin
          w_if_pc_nxt    = r_pc;
          w_if_instr_nxt = r_hold_instr;
          w_if_valid_nxt = 1'b1;
          w_pc_nxt       = w_pc_inc;
          w_state_nxt    = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_pending_pc <= 32'd0;
      r_hold_instr <= 32'd0;
      r_if_pc      <= 32'd0;
      r_if_instr   <= NOP;
      r_if_valid   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_pending_pc <= w_pending_nxt;
      r_hold_instr <= w_hold_nxt;
      r_if_pc      <= w_if_pc_nxt;
      r_if_instr   <= w_if_instr_nxt;
      r_if_valid   <= w_if_valid_nxt;
    end
  end

  // Reset withdraws the request combinationally so memory sees it drop at once.
  assign imem_read    = (r_state != S_HOLD) && !rst;
  assign imem_address = r_pc;
  assign IF_pc        = r_if_pc;
  assign IF_instr     = r_if_instr;
  assign IF_valid     = r_if_valid;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: table vectors on zero-wait memory, directed wait-state
// sequences, and a randomized run checked against an instruction-stream model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] IF_pc;
  logic [31:0] IF_instr;
  logic        IF_valid;

  if_stage #(.RESET_PC(32'h0000_0060)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_read(imem_read),
    .imem_address(imem_address), .imem_resp(imem_resp),
    .imem_rdata(imem_rdata), .IF_pc(IF_pc), .IF_instr(IF_instr),
    .IF_valid(IF_valid)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  int n_checks = 0;
  int n_err    = 0;

  // Memory model: each request waits m_wait cycles, then responds with addr^KEY.
  int          m_fixed = 0;
  bit          m_rand  = 0;
  int          m_wait  = 0;
  int          m_cnt   = 0;
  bit          m_busy  = 0;
  logic [31:0] m_addr  = 32'd0;
  int          m_viol  = 0;

  always @(negedge clk) begin
    if (imem_read) begin
      if (!m_busy) begin
        m_busy = 1;
        m_addr = imem_address;
        m_cnt  = 0;
        m_wait = m_rand ? int'($urandom_range(3, 0)) : m_fixed;
      end else if (imem_address != m_addr) begin
        m_viol++;
        m_addr = imem_address;
        m_cnt  = 0;
      end
      if (m_cnt >= m_wait) begin
        imem_resp  = 1'b1;
        imem_rdata = m_addr ^ KEY;
        m_busy     = 0;
      end else begin
        imem_resp  = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        m_cnt++;
      end
    end else begin
      imem_resp = 1'b0;
      m_busy    = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rp);
    @(negedge clk);
    stall = s;
    redirect = r;
    redirect_pc = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int wait_states, input bit rnd);
    @(negedge clk);
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    m_fixed = wait_states;
    m_rand = rnd;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Wait (bounded) for the next delivered instruction with no stall/redirect.
  task automatic wait_valid(output bit found);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 32'd0);
      if (IF_valid) found = 1;
    end
  endtask

  typedef struct packed {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic        exp_read;
  } vec_t;

  vec_t vt[16];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    bit          saw400;
    logic [31:0] first_new;
    logic [31:0] exp_next;
    logic [31:0] p_pc, p_instr;
    logic        p_valid;
    logic        s, r;
    logic [31:0] rp;
    int          n_deliv;

    vt[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h60,       32'h64,       1'b1};
    vt[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h64,       32'h68,       1'b1};
    vt[2]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h64,       32'h68,       1'b0};
    vt[3]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h64,       32'h68,       1'b0};
    vt[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h64,       32'h68,       1'b0};
    vt[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h68,       32'h6C,       1'b1};
    vt[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h6C,       32'h70,       1'b1};
    vt[7]  = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h6C,       32'h70,       1'b0};
    vt[8]  = '{1'b1, 1'b1, 32'h300,      1'b0, 32'h0,        32'h300,      1'b1};
    vt[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h300,      32'h304,      1'b1};
    vt[10] = '{1'b0, 1'b1, 32'h503,      1'b0, 32'h0,        32'h500,      1'b1};
    vt[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h500,      32'h504,      1'b1};
    vt[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h500,      32'h504,      1'b0};
    vt[13] = '{1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h0,        32'hFFFFFFFC, 1'b1};
    vt[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 32'h0,        1'b1};
    vt[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h4,        1'b1};

    // Reset values, during and just after reset.
    m_fixed = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", {31'd0, imem_read}, 32'd0);
    chk("rst_valid", {31'd0, IF_valid}, 32'd0);
    chk("rst_pc", IF_pc, 32'd0);
    chk("rst_instr", IF_instr, 32'h13);
    rst = 1'b0;
    #1;
    chk("post_rst_addr", imem_address, 32'h60);
    chk("post_rst_read", {31'd0, imem_read}, 32'd1);
    chk("post_rst_valid", {31'd0, IF_valid}, 32'd0);
    chk("post_rst_instr", IF_instr, 32'h13);

    // Zero-wait memory vectors.
    for (int i = 0; i < 16; i++) begin
      step(vt[i].stall, vt[i].redir, vt[i].rpc);
      chk($sformatf("vec%0d_valid", i), {31'd0, IF_valid}, {31'd0, vt[i].exp_valid});
      if (vt[i].exp_valid) begin
        chk($sformatf("vec%0d_pc", i), IF_pc, vt[i].exp_pc);
        chk($sformatf("vec%0d_instr", i), IF_instr, vt[i].exp_pc ^ KEY);
      end
      chk($sformatf("vec%0d_addr", i), imem_address, vt[i].exp_addr);
      chk($sformatf("vec%0d_read", i), {31'd0, imem_read}, {31'd0, vt[i].exp_read});
    end

    // Two-wait memory, redirect while 0x64 is outstanding.
    do_reset(2, 0);
    wait_valid(found);
    chk("seqA_first_found", {31'd0, found}, 32'd1);
    chk("seqA_first_pc", IF_pc, 32'h60);
    chk("seqA_next_addr", imem_address, 32'h64);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h200);
    chk("seqA_drop_valid", {31'd0, IF_valid}, 32'd0);
    chk("seqA_drop_addr", imem_address, 32'h64);
    chk("seqA_drop_read", {31'd0, imem_read}, 32'd1);
    step(1'b0, 1'b0, 32'd0);
    chk("seqA_tgt_addr", imem_address, 32'h200);
    chk("seqA_tgt_valid", {31'd0, IF_valid}, 32'd0);
    wait_valid(found);
    chk("seqA_tgt_found", {31'd0, found}, 32'd1);
    chk("seqA_tgt_pc", IF_pc, 32'h200);
    chk("seqA_tgt_instr", IF_instr, 32'h200 ^ KEY);

    // Three-wait memory, two redirects during one outstanding fetch.
    do_reset(3, 0);
    wait_valid(found);
    chk("seqB_first_pc", IF_pc, 32'h60);
    step(1'b0, 1'b1, 32'h400);
    chk("seqB_r1_addr", imem_address, 32'h64);
    chk("seqB_r1_valid", {31'd0, IF_valid}, 32'd0);
    step(1'b0, 1'b1, 32'h503);
    chk("seqB_r2_addr", imem_address, 32'h64);
    saw400 = 0;
    first_new = 32'hFFFF_FFFF;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 32'd0);
      if (imem_address == 32'h400) saw400 = 1;
      if (first_new == 32'hFFFF_FFFF && imem_address != 32'h64) first_new = imem_address;
      if (IF_valid) found = 1;
    end
    chk("seqB_found", {31'd0, found}, 32'd1);
    chk("seqB_pc", IF_pc, 32'h500);
    chk("seqB_first_new_addr", first_new, 32'h500);
    chk("seqB_no_400", {31'd0, saw400}, 32'd0);

    // Reset pulsed mid-wait.
    do_reset(3, 0);
    wait_valid(found);
    chk("seqC_first_pc", IF_pc, 32'h60);
    step(1'b0, 1'b0, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("seqC_rst_read", {31'd0, imem_read}, 32'd0);
    chk("seqC_rst_valid", {31'd0, IF_valid}, 32'd0);
    chk("seqC_rst_pc", IF_pc, 32'd0);
    chk("seqC_rst_instr", IF_instr, 32'h13);
    chk("seqC_rst_addr", imem_address, 32'h60);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("seqC_post_read", {31'd0, imem_read}, 32'd1);
    wait_valid(found);
    chk("seqC_post_found", {31'd0, found}, 32'd1);
    chk("seqC_post_pc", IF_pc, 32'h60);

    // Randomized run against the in-order instruction stream model.
    do_reset(0, 1);
    exp_next = 32'h60;
    p_pc = IF_pc;
    p_instr = IF_instr;
    p_valid = IF_valid;
    n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      s  = ($urandom_range(99, 0) < 30);
      r  = ($urandom_range(99, 0) < 8);
      rp = $urandom;
      step(s, r, rp);
      if (r) begin
        chk("rnd_redirect_valid", {31'd0, IF_valid}, 32'd0);
        exp_next = {rp[31:2], 2'b00};
      end else if (s) begin
        chk("rnd_stall_valid", {31'd0, IF_valid}, {31'd0, p_valid});
        chk("rnd_stall_pc", IF_pc, p_pc);
        chk("rnd_stall_instr", IF_instr, p_instr);
      end else if (IF_valid) begin
        chk("rnd_pc", IF_pc, exp_next);
        chk("rnd_instr", IF_instr, exp_next ^ KEY);
        exp_next = exp_next + 32'd4;
        n_deliv++;
      end
      p_pc = IF_pc;
      p_instr = IF_instr;
      p_valid = IF_valid;
    end
    chk("rnd_progress", {31'd0, n_deliv > 300}, 32'd1);
    chk("addr_stable_while_pending", m_viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
